// File: rtl/wb_trace_uart.sv
// wb_trace_uart: captures committed register write-backs into a FIFO and streams
// framed bytes out an 8N1 UART pin. The optional macro TRACE_PC_EN adds the PC to
// each entry and frame.
module wb_trace_uart #(
    parameter int         DEPTH        = 16,
    parameter int         CLKS_PER_BIT = 868,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     TraceEn,
    input  logic                     WbValid,
    input  logic [4:0]               WbReg,
    input  logic [31:0]              WbData,
    input  logic [31:0]              WbPC,
    output logic                     Tx,
    output logic                     Busy,
    output logic                     Overflow,
    output logic [15:0]              DropCount,
    output logic [$clog2(DEPTH):0]   Level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(CLKS_PER_BIT);
`ifdef TRACE_PC_EN
    localparam int EW = 69;
    localparam int NB = 10;
`else
    localparam int EW = 37;
    localparam int NB = 6;
`endif
    localparam int FW = NB * 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] entry_in, head;
    logic [FW-1:0] frame_new, frame_q, frame_d;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0] level_q, level_d;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [3:0]    byte_q, byte_d;
    logic [15:0]   drop_q, drop_d;
    logic [7:0]    cur_byte;
    logic          ovf_q, ovf_d, tx_q, tx_d;
    logic          eligible, full, push, drop, pop, last;

    assign head = mem_q[rd_q];
`ifdef TRACE_PC_EN
    assign entry_in  = {WbPC, WbReg, WbData};
    assign frame_new = {SYNC_BYTE, 3'b000, head[36:32], head[68:37], head[31:0]};
`else
    logic unused_pc;
    assign unused_pc = ^WbPC;
    assign entry_in  = {WbReg, WbData};
    assign frame_new = {SYNC_BYTE, 3'b000, head[36:32], head[31:0]};
`endif

    // Full is judged on the registered level, so a same-cycle pop never makes room for a push.
    assign eligible = WbValid & TraceEn & (WbReg != 5'd0);
    assign full     = level_q == LW'(DEPTH);
    assign push     = eligible & ~full;
    assign drop     = eligible & full;
    assign pop      = (state_q == S_IDLE) & (level_q != '0);
    assign last     = cnt_q == CW'(CLKS_PER_BIT - 1);
    assign cur_byte = frame_q[FW-1 -: 8];

    // FIFO pointers, occupancy and sticky drop accounting.
    always_comb begin
        wr_d    = wr_q + AW'(push);
        rd_d    = rd_q + AW'(pop);
        level_d = level_q + LW'(push) - LW'(pop);
        ovf_d   = ovf_q | drop;
        drop_d  = drop_q + 16'(drop && drop_q != 16'hFFFF);
    end

    // UART framing FSM: the frame register shifts up one byte per transmitted byte.
    always_comb begin
        state_d = state_q;
        cnt_d   = (state_q == S_IDLE) ? cnt_q : (last ? '0 : cnt_q + 1'b1);
        bit_d   = bit_q;
        byte_d  = byte_q;
        frame_d = frame_q;
        case (state_q)
            S_IDLE: if (pop) begin
                state_d = S_START;
                frame_d = frame_new;
                byte_d  = 4'(NB - 1);
            end
            S_START: if (last) begin
                state_d = S_DATA;
                bit_d   = 3'd0;
            end
            S_DATA: if (last) begin
                bit_d   = bit_q + 1'b1;
                state_d = (bit_q == 3'd7) ? S_STOP : S_DATA;
            end
            default: if (last) begin
                state_d = (byte_q != 4'd0) ? S_START : S_IDLE;
                byte_d  = (byte_q != 4'd0) ? byte_q - 1'b1 : byte_q;
                frame_d = (byte_q != 4'd0) ? frame_q << 8 : frame_q;
            end
        endcase
    end

    // Tx follows the current state one cycle later from a flop, keeping the pin glitch-free.
    always_comb begin
        tx_d = (state_q == S_START) ? 1'b0 : (state_q == S_DATA) ? cur_byte[bit_q] : 1'b1;
    end

    // Entry storage needs no reset; the pointers define what is valid.
    always_ff @(posedge Clk) begin
        if (push) mem_q[wr_q] <= entry_in;
    end

    // All control state, asynchronously cleared with Tx forced idle-high.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            frame_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            frame_q <= frame_d;
            tx_q    <= tx_d;
        end
    end

    assign Tx        = tx_q;
    assign Busy      = state_q != S_IDLE;
    assign Overflow  = ovf_q;
    assign DropCount = drop_q;
    assign Level     = level_q;
endmodule
